// File: rtl/display_source_arbiter.sv
// Time-shares the 4-digit display between live time, a captured lap and an alert,
// with a minimum hold time and a blank gap at every switch. Optional: DISPLAY_ARB_BLINK_EN.
module display_source_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 300_000_000,
  parameter int unsigned GAP_CYCLES   = 200_000,
  parameter int unsigned BLINK_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] live_number,
  input  logic [3:0]  live_dp,
  input  logic        lap_req,
  input  logic [15:0] lap_number,
  input  logic [3:0]  lap_dp,
  input  logic        alert_req,
  input  logic [15:0] alert_number,
  output logic [15:0] number,
  output logic [3:0]  dp,
  output logic        blank,
  output logic [2:0]  grant
);

  typedef enum logic [1:0] {LIVE, GAP, LAP, ALERT} state_t;

  state_t      state, nxt, pick, leave;
  logic [31:0] cnt;
  logic        lap_pend, alert_pend;
  logic [15:0] lap_num_q, alert_num_q;
  logic [3:0]  lap_dp_q;
  logic        expire, enter;
`ifdef DISPLAY_ARB_BLINK_EN
  logic [31:0] blink_cnt;
`endif

  // enter marks a (re)load of the next state: a state change or a refresh of the shown source
  always_comb begin
    pick   = alert_pend ? ALERT : (lap_pend ? LAP : LIVE);
    leave  = (GAP_CYCLES == 0) ? pick : GAP;
    expire = (cnt <= 32'd1);
    nxt    = state;
    enter  = 1'b0;
    case (state)
      LIVE:    if (alert_pend || lap_pend) nxt = leave;
      GAP:     if (expire) nxt = pick;
      LAP: begin
        if (alert_pend)    nxt = leave;
        else if (lap_pend) enter = 1'b1;
        else if (expire)   nxt = leave;
      end
      ALERT: begin
        if (alert_pend)  enter = 1'b1;
        else if (expire) nxt = leave;
      end
      default: nxt = LIVE;
    endcase
    if (nxt != state) enter = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LIVE;
      cnt         <= 32'd0;
      lap_pend    <= 1'b0;
      alert_pend  <= 1'b0;
      lap_num_q   <= 16'h0000;
      lap_dp_q    <= 4'h0;
      alert_num_q <= 16'h0000;
      number      <= 16'h0000;
      dp          <= 4'h0;
      blank       <= 1'b0;
      grant       <= 3'b001;
`ifdef DISPLAY_ARB_BLINK_EN
      blink_cnt   <= 32'd0;
`endif
    end else begin
      state <= nxt;
      // a fresh request in the same cycle as entry keeps the flag set
      lap_pend   <= lap_req   | (lap_pend   & ~(enter && nxt == LAP));
      alert_pend <= alert_req | (alert_pend & ~(enter && nxt == ALERT));
      if (lap_req) begin
        lap_num_q <= lap_number;
        lap_dp_q  <= lap_dp;
      end
      if (alert_req) alert_num_q <= alert_number;

      if (enter && nxt == GAP)                      cnt <= GAP_CYCLES;
      else if (enter && (nxt == LAP || nxt == ALERT)) cnt <= HOLD_CYCLES;
      else if (cnt != 32'd0)                        cnt <= cnt - 32'd1;

      case (nxt)
        LIVE: begin
          number <= live_number;
          dp     <= live_dp;
          blank  <= 1'b0;
          grant  <= 3'b001;
        end
        GAP: begin
          blank <= 1'b1;
          grant <= 3'b000;
        end
        LAP: begin
          if (enter) begin
            number <= lap_num_q;
            dp     <= lap_dp_q;
          end
          blank <= 1'b0;
          grant <= 3'b010;
        end
        default: begin
          if (enter) begin
            number <= alert_num_q;
            dp     <= 4'h0;
          end
          grant <= 3'b100;
`ifdef DISPLAY_ARB_BLINK_EN
          if (enter) begin
            blank     <= 1'b0;
            blink_cnt <= BLINK_CYCLES - 1;
          end else if (blink_cnt == 32'd0) begin
            blank     <= ~blank;
            blink_cnt <= BLINK_CYCLES - 1;
          end else begin
            blink_cnt <= blink_cnt - 32'd1;
          end
`else
          blank <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_source_arbiter.sv
// Bench for display_source_arbiter: directed scenarios plus a randomized run
// checked against a phase/remaining-time model of the display schedule.
module tb_display_source_arbiter;
  localparam int HOLD  = 10;
  localparam int GAPC  = 2;
  localparam int BLINK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] live_number = 16'h0000;
  logic [3:0]  live_dp = 4'h0;
  logic        lap_req = 1'b0;
  logic [15:0] lap_number = 16'h0000;
  logic [3:0]  lap_dp = 4'h0;
  logic        alert_req = 1'b0;
  logic [15:0] alert_number = 16'h0000;
  logic [15:0] number;
  logic [3:0]  dp;
  logic        blank;
  logic [2:0]  grant;

  int n_vec = 0;
  int n_err = 0;

  display_source_arbiter #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .rst(rst),
    .live_number(live_number), .live_dp(live_dp),
    .lap_req(lap_req), .lap_number(lap_number), .lap_dp(lap_dp),
    .alert_req(alert_req), .alert_number(alert_number),
    .number(number), .dp(dp), .blank(blank), .grant(grant)
  );

  always #5 clk = ~clk;

  // Reference model: which source is on screen (0 live, 1 lap, 2 alert, 3 gap)
  // and how many cycles of the current phase remain.
  int          m_src = 0;
  int          m_left = 0;
  bit          m_plap = 0, m_palert = 0;
  logic [15:0] m_lnum = 16'h0, m_anum = 16'h0;
  logic [3:0]  m_ldp = 4'h0;
  logic [15:0] e_num = 16'h0;
  logic [3:0]  e_dp = 4'h0;
  logic        e_blank = 1'b0;
  logic [2:0]  e_grant = 3'b001;

  function automatic bit exp_blink(int elapsed);
`ifdef DISPLAY_ARB_BLINK_EN
    return ((elapsed / BLINK) % 2) == 1;
`else
    return elapsed < 0;
`endif
  endfunction

  task automatic m_show(int s);
    m_src = s;
    e_blank = 1'b0;
    if (s == 0) begin
      e_num = live_number; e_dp = live_dp; e_grant = 3'b001;
    end else if (s == 1) begin
      m_left = HOLD; m_plap = 0; e_num = m_lnum; e_dp = m_ldp; e_grant = 3'b010;
    end else begin
      m_left = HOLD; m_palert = 0; e_num = m_anum; e_dp = 4'h0; e_grant = 3'b100;
    end
  endtask

  function automatic int m_pick();
    return m_palert ? 2 : (m_plap ? 1 : 0);
  endfunction

  task automatic m_switch();
    if (GAPC == 0) m_show(m_pick());
    else begin
      m_src = 3; m_left = GAPC; e_blank = 1'b1; e_grant = 3'b000;
    end
  endtask

  task automatic m_step();
    if (rst) begin
      m_src = 0; m_left = 0; m_plap = 0; m_palert = 0;
      m_lnum = 16'h0; m_anum = 16'h0; m_ldp = 4'h0;
      e_num = 16'h0; e_dp = 4'h0; e_blank = 1'b0; e_grant = 3'b001;
      return;
    end
    case (m_src)
      0: if (m_plap || m_palert) m_switch(); else m_show(0);
      3: begin m_left--; if (m_left == 0) m_show(m_pick()); end
      1: begin
        if (m_palert) m_switch();
        else if (m_plap) m_show(1);
        else begin m_left--; if (m_left == 0) m_switch(); end
      end
      default: begin
        if (m_palert) m_show(2);
        else begin m_left--; if (m_left == 0) m_switch(); end
      end
    endcase
    if (m_src == 2) e_blank = exp_blink(HOLD - m_left);
    if (lap_req)   begin m_plap = 1; m_lnum = lap_number; m_ldp = lap_dp; end
    if (alert_req) begin m_palert = 1; m_anum = alert_number; end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_vec++;
      if ({grant, blank, number, dp} !== {3'b001, 1'b0, 16'h0000, 4'h0}) begin
        n_err++;
        $display("FAIL reset k=%0d got %h want %h", k, {grant, blank, number, dp}, {3'b001, 1'b0, 16'h0000, 4'h0});
      end
    end
    rst = 1'b0;
    live_number = 16'h1234; live_dp = 4'b0100;
    cyc();
    n_vec++;
    if ({grant, blank, number, dp} !== {3'b001, 1'b0, 16'h1234, 4'b0100}) begin
      n_err++;
      $display("FAIL live_path got %h want %h", {grant, blank, number, dp}, {3'b001, 1'b0, 16'h1234, 4'b0100});
    end
  endtask

  task automatic test_lap();
    lap_number = 16'h0599; lap_dp = 4'b0010; lap_req = 1'b1;
    cyc();
    lap_req = 1'b0;
    n_vec++;
    if (grant !== 3'b001) begin n_err++; $display("FAIL lap_pend_cycle got %b want 001", grant); end
    for (int k = 0; k < GAPC + HOLD + GAPC; k++) begin
      cyc();
      n_vec++;
      if (k < GAPC || k >= GAPC + HOLD) begin
        if ({grant, blank} !== 4'b0001) begin
          n_err++; $display("FAIL lap_gap k=%0d got grant=%b blank=%b want 000/1", k, grant, blank);
        end
      end else if ({grant, blank, number, dp} !== {3'b010, 1'b0, 16'h0599, 4'b0010}) begin
        n_err++; $display("FAIL lap_show k=%0d got %h want %h", k, {grant, blank, number, dp}, {3'b010, 1'b0, 16'h0599, 4'b0010});
      end
    end
    cyc();
    n_vec++;
    if ({grant, blank, number, dp} !== {3'b001, 1'b0, 16'h1234, 4'b0100}) begin
      n_err++; $display("FAIL lap_back_live got %h want %h", {grant, blank, number, dp}, {3'b001, 1'b0, 16'h1234, 4'b0100});
    end
  endtask

  // expects an alert hold of HOLD cycles followed by a gap
  task automatic check_alert(string tag, logic [15:0] val);
    for (int k = 0; k < HOLD + GAPC; k++) begin
      cyc();
      n_vec++;
      if (k >= HOLD) begin
        if ({grant, blank} !== 4'b0001) begin
          n_err++; $display("FAIL %s_gap k=%0d got grant=%b blank=%b want 000/1", tag, k, grant, blank);
        end
      end else if ({grant, blank, number, dp} !== {3'b100, exp_blink(k), val, 4'h0}) begin
        n_err++; $display("FAIL %s_alert k=%0d got %h want %h", tag, k, {grant, blank, number, dp}, {3'b100, exp_blink(k), val, 4'h0});
      end
    end
  endtask

  task automatic test_preempt();
    lap_number = 16'h0777; lap_dp = 4'b1000; lap_req = 1'b1;
    cyc();
    lap_req = 1'b0;
    for (int k = 0; k < GAPC + 4; k++) cyc();
    n_vec++;
    if ({grant, number} !== {3'b010, 16'h0777}) begin
      n_err++; $display("FAIL preempt_lap_on got %h want %h", {grant, number}, {3'b010, 16'h0777});
    end
    alert_number = 16'hEEEE; alert_req = 1'b1;
    cyc();
    alert_req = 1'b0;
    n_vec++;
    if (grant !== 3'b010) begin n_err++; $display("FAIL preempt_req_cycle got %b want 010", grant); end
    for (int k = 0; k < GAPC; k++) begin
      cyc();
      n_vec++;
      if ({grant, blank} !== 4'b0001) begin
        n_err++; $display("FAIL preempt_gap k=%0d got grant=%b blank=%b want 000/1", k, grant, blank);
      end
    end
    check_alert("preempt", 16'hEEEE);
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_vec++;
      if ({grant, blank, number} !== {3'b001, 1'b0, 16'h1234}) begin
        n_err++; $display("FAIL preempt_no_resume k=%0d got %h want %h", k, {grant, blank, number}, {3'b001, 1'b0, 16'h1234});
      end
    end
  endtask

  task automatic test_simultaneous();
    lap_number = 16'h0321; lap_dp = 4'b0001; alert_number = 16'hABCD;
    lap_req = 1'b1; alert_req = 1'b1;
    cyc();
    lap_req = 1'b0; alert_req = 1'b0;
    for (int k = 0; k < GAPC; k++) begin
      cyc();
      n_vec++;
      if ({grant, blank} !== 4'b0001) begin
        n_err++; $display("FAIL simul_gap k=%0d got grant=%b blank=%b want 000/1", k, grant, blank);
      end
    end
    check_alert("simul", 16'hABCD);
    for (int k = 0; k < HOLD + GAPC; k++) begin
      cyc();
      n_vec++;
      if (k >= HOLD) begin
        if ({grant, blank} !== 4'b0001) begin
          n_err++; $display("FAIL simul_gap2 k=%0d got grant=%b blank=%b want 000/1", k, grant, blank);
        end
      end else if ({grant, blank, number, dp} !== {3'b010, 1'b0, 16'h0321, 4'b0001}) begin
        n_err++; $display("FAIL simul_lap k=%0d got %h want %h", k, {grant, blank, number, dp}, {3'b010, 1'b0, 16'h0321, 4'b0001});
      end
    end
    cyc();
    n_vec++;
    if ({grant, blank, number} !== {3'b001, 1'b0, 16'h1234}) begin
      n_err++; $display("FAIL simul_live got %h want %h", {grant, blank, number}, {3'b001, 1'b0, 16'h1234});
    end
  endtask

  task automatic test_reset_mid_hold();
    lap_number = 16'h0599; lap_dp = 4'b0010; lap_req = 1'b1;
    cyc();
    lap_req = 1'b0;
    for (int k = 0; k < GAPC + 3; k++) cyc();
    rst = 1'b1; lap_req = 1'b1; alert_req = 1'b1; live_number = 16'h4321;
    cyc();
    rst = 1'b0; lap_req = 1'b0; alert_req = 1'b0;
    n_vec++;
    if ({grant, blank, number, dp} !== {3'b001, 1'b0, 16'h0000, 4'h0}) begin
      n_err++; $display("FAIL rst_mid_hold got %h want %h", {grant, blank, number, dp}, {3'b001, 1'b0, 16'h0000, 4'h0});
    end
    for (int k = 0; k < GAPC + 4; k++) begin
      cyc();
      n_vec++;
      if ({grant, blank, number, dp} !== {3'b001, 1'b0, 16'h4321, 4'b0100}) begin
        n_err++; $display("FAIL rst_pend_clear k=%0d got %h want %h", k, {grant, blank, number, dp}, {3'b001, 1'b0, 16'h4321, 4'b0100});
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      live_number  = 16'($urandom);
      live_dp      = 4'($urandom);
      lap_number   = 16'($urandom);
      lap_dp       = 4'($urandom);
      alert_number = 16'($urandom);
      lap_req      = ($urandom_range(0, 15) == 0);
      alert_req    = ($urandom_range(0, 28) == 0);
      rst          = ($urandom_range(0, 250) == 0);
      cyc();
      n_vec++;
      if (e_grant == 3'b000) begin
        if ({grant, blank} !== {e_grant, e_blank}) begin
          n_err++; $display("FAIL random_gap k=%0d got grant=%b blank=%b want %b/%b", k, grant, blank, e_grant, e_blank);
        end
      end else if ({grant, blank, number, dp} !== {e_grant, e_blank, e_num, e_dp}) begin
        n_err++; $display("FAIL random k=%0d got %h want %h", k, {grant, blank, number, dp}, {e_grant, e_blank, e_num, e_dp});
      end
    end
    rst = 1'b0; lap_req = 1'b0; alert_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lap();
    test_preempt();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
